// File: rtl/clk_gen_scheduler.sv
// Programmable divided-clock burst generator: accepts a start request with period,
// burst length and start delay, then issues tick/clk_out for the requested half periods.
module clk_gen_scheduler #(
  parameter int CNT_WIDTH  = 32,
  parameter int TICK_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CNT_WIDTH-1:0]  cfg_unit,
  input  logic [TICK_WIDTH-1:0] cfg_ticks,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_cfg,
  output logic                  tick,
  output logic                  clk_out,
  output logic [TICK_WIDTH-1:0] tick_count
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_unit, w_unit_nxt;
  logic [CNT_WIDTH-1:0]  r_delay, w_delay_nxt;
  logic [TICK_WIDTH-1:0] r_ticks, w_ticks_nxt;
  logic [TICK_WIDTH-1:0] r_tick_count, w_tick_count_nxt;
  logic                  r_busy, r_done, r_aborted, r_err_cfg, r_tick, r_clk_out;
  logic                  w_done_nxt, w_aborted_nxt, w_err_cfg_nxt, w_tick_nxt, w_clk_out_nxt;

  // Next-state and next-output logic; all status outputs are pulses unless set here.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_unit_nxt       = r_unit;
    w_delay_nxt      = r_delay;
    w_ticks_nxt      = r_ticks;
    w_tick_count_nxt = r_tick_count;
    w_clk_out_nxt    = r_clk_out;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = 1'b0;
    w_err_cfg_nxt    = 1'b0;
    w_tick_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if ((cfg_unit == {CNT_WIDTH{1'b0}}) || (cfg_ticks == {TICK_WIDTH{1'b0}})) begin
            w_err_cfg_nxt = 1'b1;
          end else begin
            w_unit_nxt       = cfg_unit;
            w_ticks_nxt      = cfg_ticks;
            w_delay_nxt      = cfg_delay;
            w_cnt_nxt        = {CNT_WIDTH{1'b0}};
            w_tick_count_nxt = {TICK_WIDTH{1'b0}};
            w_clk_out_nxt    = 1'b0;
            w_state_nxt      = (cfg_delay != {CNT_WIDTH{1'b0}}) ? S_DELAY : S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DELAY: begin
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
          w_clk_out_nxt = 1'b0;
          w_cnt_nxt     = {CNT_WIDTH{1'b0}};
        end else if (r_cnt == (r_delay - CNT_WIDTH'(1))) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = {CNT_WIDTH{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      S_RUN: begin
        // Abort outranks the final tick, so a coincident abort leaves tick_count unincremented.
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
          w_clk_out_nxt = 1'b0;
          w_cnt_nxt     = {CNT_WIDTH{1'b0}};
        end else if (r_cnt == r_unit) begin
          w_cnt_nxt        = {CNT_WIDTH{1'b0}};
          w_tick_nxt       = 1'b1;
          w_tick_count_nxt = r_tick_count + TICK_WIDTH'(1);
          if (r_tick_count == (r_ticks - TICK_WIDTH'(1))) begin
            w_state_nxt   = S_DONE;
            w_done_nxt    = 1'b1;
            w_clk_out_nxt = 1'b0;
          end else begin
            w_clk_out_nxt = ~r_clk_out;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_out_nxt = 1'b0;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CNT_WIDTH{1'b0}};
      r_unit       <= {CNT_WIDTH{1'b0}};
      r_delay      <= {CNT_WIDTH{1'b0}};
      r_ticks      <= {TICK_WIDTH{1'b0}};
      r_tick_count <= {TICK_WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err_cfg    <= 1'b0;
      r_tick       <= 1'b0;
      r_clk_out    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_unit       <= w_unit_nxt;
      r_delay      <= w_delay_nxt;
      r_ticks      <= w_ticks_nxt;
      r_tick_count <= w_tick_count_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_err_cfg    <= w_err_cfg_nxt;
      r_tick       <= w_tick_nxt;
      r_clk_out    <= w_clk_out_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign err_cfg    = r_err_cfg;
  assign tick       = r_tick;
  assign clk_out    = r_clk_out;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_clk_gen_scheduler.sv
// Scoreboard bench for clk_gen_scheduler: expected tick/done/abort/err events are
// derived in closed form when a request is driven and popped as the DUT emits them.
module tb_clk_gen_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cfg_unit, cfg_delay;
  logic [23:0] cfg_ticks;
  logic        start, abort;
  logic        busy, done, aborted, err_cfg, tick, clk_out;
  logic [23:0] tick_count;

  typedef struct {
    int       cyc;
    logic [4:0] flags;  // {tick, done, aborted, err_cfg, clk_out}
    int       tcount;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  last_tc = 0;

  clk_gen_scheduler #(.CNT_WIDTH(32), .TICK_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_unit(cfg_unit), .cfg_ticks(cfg_ticks),
    .cfg_delay(cfg_delay), .start(start), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .err_cfg(err_cfg), .tick(tick), .clk_out(clk_out),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (tick || done || aborted || err_cfg) begin
      if (q.size() == 0) begin
        check("spurious_event", 64'({tick, done, aborted, err_cfg, clk_out}), 64'(0));
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("event_flags", 64'({tick, done, aborted, err_cfg, clk_out}), 64'(e.flags));
        check("event_tick_count", 64'(tick_count), 64'(e.tcount));
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_burst(input int c, input int unit, input int ticks, input int delay,
                            input int abort_cyc);
    int  r;
    ev_t e;
    r = c + 1 + delay;
    for (int k = 1; k <= ticks; k++) begin
      int tc;
      tc = r + k * (unit + 1);
      if (abort_cyc >= 0 && tc > abort_cyc) begin
        e.cyc = abort_cyc + 1; e.flags = 5'b00100; e.tcount = k - 1;
        q.push_back(e);
        last_tc = k - 1;
        return;
      end
      e.cyc = tc;
      e.flags = (k == ticks) ? 5'b11000 : {1'b1, 3'b000, k[0]};
      e.tcount = k;
      q.push_back(e);
    end
    last_tc = ticks;
  endtask

  task automatic go(input int u, input int t, input int d, input int abort_rel, output int c0);
    ev_t e;
    c0 = cyc;
    cfg_unit = 32'(u); cfg_ticks = 24'(t); cfg_delay = 32'(d);
    start = 1'b1;
    if (u == 0 || t == 0) begin
      e.cyc = c0 + 1; e.flags = 5'b00010; e.tcount = last_tc;
      q.push_back(e);
    end else begin
      push_burst(c0, u, t, d, (abort_rel < 0) ? -1 : c0 + abort_rel);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      next_cyc();
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int c0, rel;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_unit = 32'd0; cfg_ticks = 24'd0; cfg_delay = 32'd0;
    repeat (3) next_cyc();
    check("reset_outputs", 64'({busy, done, aborted, err_cfg, tick, clk_out, tick_count}), 64'(0));
    reset_n = 1'b1;
    next_cyc();

    // Basic burst with per-cycle clk_out/busy checks and an ignored start while busy.
    go(3, 4, 0, -1, c0);
    next_cyc();
    start = 1'b0;
    while (cyc - c0 <= 18) begin
      rel = cyc - c0;
      check("t1_clk_out", 64'(clk_out),
            64'(((rel >= 5 && rel <= 8) || (rel >= 13 && rel <= 16)) ? 1 : 0));
      check("t1_busy", 64'(busy), 64'((rel >= 1 && rel <= 17) ? 1 : 0));
      if (rel == 3) begin
        cfg_unit = 32'd2; cfg_ticks = 24'd10; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      next_cyc();
    end
    wait_drain();

    // Rejected configurations: unit=0 then ticks=0.
    go(0, 5, 0, -1, c0);
    next_cyc(); start = 1'b0;
    check("err_unit_busy", 64'(busy), 64'(0));
    check("err_unit_tick_count", 64'(tick_count), 64'(4));
    next_cyc();
    go(2, 0, 0, -1, c0);
    next_cyc(); start = 1'b0;
    check("err_ticks_busy", 64'(busy), 64'(0));
    next_cyc();
    wait_drain();

    // Delayed burst with odd tick count; last tick forces clk_out low.
    go(1, 3, 5, -1, c0);
    next_cyc(); start = 1'b0;
    check("t2_busy_delay", 64'(busy), 64'(1));
    wait_drain();
    next_cyc();
    check("t2_busy_after", 64'(busy), 64'(0));

    // Abort mid-run at relative cycle 10.
    go(3, 8, 0, 10, c0);
    next_cyc(); start = 1'b0;
    while (cyc - c0 < 10) next_cyc();
    abort = 1'b1;
    next_cyc(); abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_clk_out", 64'(clk_out), 64'(0));
    wait_drain();
    next_cyc();

    // Abort coincident with the final tick condition.
    go(2, 2, 0, 6, c0);
    next_cyc(); start = 1'b0;
    while (cyc - c0 < 6) next_cyc();
    abort = 1'b1;
    next_cyc(); abort = 1'b0;
    wait_drain();
    check("abort_last_tick_count", 64'(tick_count), 64'(1));
    next_cyc();

    // Abort in IDLE suppresses start, both for bad and good configurations.
    cfg_unit = 32'd0; cfg_ticks = 24'd3; start = 1'b1; abort = 1'b1;
    next_cyc();
    cfg_unit = 32'd2;
    next_cyc();
    start = 1'b0; abort = 1'b0;
    next_cyc();
    check("idle_abort_busy", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a run.
    go(3, 8, 0, -1, c0);
    next_cyc(); start = 1'b0;
    while (cyc - c0 < 7) next_cyc();
    q.delete();
    last_tc = 0;
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs",
             64'({busy, done, aborted, err_cfg, tick, clk_out, tick_count}), 64'(0));
    next_cyc();
    reset_n = 1'b1;
    next_cyc();
    next_cyc();
    check("post_reset_busy", 64'(busy), 64'(0));
    check("final_queue_empty", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_gen_scheduler.md
Name: clk_gen_scheduler

Overview:
- Run-time programmable controller for the correlator's divided sample clock.
- Accepts a start request with period, burst length and start delay, then runs a divide-by-counter for exactly the requested number of half-period ticks.
- Drives clk_out/tick to the sampling and accumulation logic, and reports busy/done/abort status to the host-side control registers.

Parameters:
- CNT_WIDTH, 32, width of cfg_unit, cfg_delay and the internal cycle counter.
- TICK_WIDTH, 24, width of cfg_ticks and tick_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_unit  in  CNT_WIDTH  half-period setting; half period = cfg_unit+1 clk cycles.
- cfg_ticks  in  TICK_WIDTH  number of ticks (half periods) in the burst.
- cfg_delay  in  CNT_WIDTH  clk cycles spent in DELAY before RUN.
- start  in  1  request pulse/level, sampled only in IDLE.
- abort  in  1  terminate any active burst.
- busy  out  1  high in DELAY, RUN, DONE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an active burst is aborted.
- err_cfg  out  1  one-cycle pulse when start is rejected.
- tick  out  1  one-cycle pulse per half period.
- clk_out  out  1  divided clock.
- tick_count  out  TICK_WIDTH  ticks issued in current/last burst.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0. Reset is honoured mid-burst with no done or aborted pulse.
- Registered outputs only; no combinational path from inputs to outputs.
- IDLE, start=1, abort=0:
  - cfg_unit==0 or cfg_ticks==0: err_cfg=1 next cycle; stay IDLE; tick_count is not cleared.
  - Otherwise latch cfg_*; clear tick_count and cnt.
  - Next state is DELAY if cfg_delay!=0, else RUN. busy=1 from the next cycle.
- Config inputs are ignored outside the accept cycle. start outside IDLE is ignored (no queueing).
- DELAY: counts cfg_delay cycles, occupying exactly cfg_delay cycles, then RUN with cnt=0.
- RUN, on entry cycle R (cnt=0):
  - cnt increments each cycle.
  - When cnt==unit: cnt<=0, tick<=1, clk_out<=~clk_out, tick_count<=tick_count+1.
  - Ticks are visible at R+unit+1 and every unit+1 cycles thereafter.
- Last tick (tick_count==ticks-1 when cnt==unit): next state DONE.
  - In DONE: tick=1, done=1, tick_count=ticks, clk_out forced 0 regardless of parity.
- DONE lasts 1 cycle, then IDLE with busy=0.
- tick_count holds its final value until the next accepted start.
- abort=1 in DELAY or RUN: next cycle state IDLE, busy=0, clk_out=0, tick=0, aborted=1, done=0, tick_count holds.
  - abort in the same cycle as the last-tick condition: abort wins (no done, tick_count not incremented).
  - abort in DONE: ignored (done already issued).
- abort=1 in IDLE: no effect; also suppresses a simultaneous start (no err_cfg).
- Width rules:
  - cnt compare is full CNT_WIDTH unsigned; cfg_unit max 2^CNT_WIDTH-1 is legal, no wrap before compare.
  - tick_count never wraps, since ticks ≤ 2^TICK_WIDTH-1.
- clk_out is a logic-level divided signal, not used as a clock inside this block.

Test Plan:
- Reset, then unit=3, ticks=4, delay=0, start at cycle 0 -> expected response:
  - busy=1 from cycle 1.
  - tick at cycles 5, 9, 13, 17.
  - clk_out=1 during cycles 5-8 and 13-16, 0 otherwise.
  - done and tick_count=4 at cycle 17; busy=0 at cycle 18.
- unit=1, ticks=3 (odd), delay=5, start at 0 -> expected response:
  - DELAY cycles 1-5, RUN from 6.
  - tick at cycles 8, 10, 12.
  - clk_out=0 at cycle 12 (forced); done at 12.
- start with unit=0, or with ticks=0 -> err_cfg pulse next cycle, busy stays 0, tick_count unchanged. A second start while busy (unit=2, ticks=10) is ignored and the first burst completes unchanged.
- unit=3, ticks=8, abort asserted at cycle 10 -> expected response:
  - aborted=1 and busy=0 at cycle 11.
  - clk_out=0; tick_count=2.
  - No done pulse.
- abort coincident with the last-tick cycle (unit=2, ticks=2, abort when cnt==2 on the second tick) -> aborted=1, done=0, tick_count=1. Separately, reset_n low mid-RUN -> all outputs 0 immediately, with no clk edge required.
